// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream interface of uart_rx_fifo: FIFO head word with a valid/ready handshake.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_perr;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_data, output m_perr, output m_valid, input m_ready);
    modport slave  (input m_data, input m_perr, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled, majority-voted UART receiver feeding a first-word-fall-through FIFO.
// Reports parity per word, and framing/overflow errors as single-clock pulses.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          sample_tick,
    input  logic                          rx,
    uart_rx_fifo_if.master                m,
    output logic                          busy,
    output logic                          ferr,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW    = $clog2(OVERSAMPLE);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int NW    = AW + 1;
    localparam int WW    = DATA_BITS + 1;
    localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [2:0]           vote_q, vote_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic [WW-1:0]        hold_q, hold_d;
    logic [WW-1:0]        mem_q [FIFO_DEPTH];
    logic [WW-1:0]        head;
    logic                 v, push, frame_err, pop, full, wr_en;

    assign v = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

    always_comb begin
        sync_d = {sync_q[0], rx};
        vote_d = sample_tick ? {vote_q[1:0], sync_q[1]} : vote_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        data_d    = data_q;
        perr_d    = perr_q;
        push      = 1'b0;
        frame_err = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!v) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = v ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d         = '0;
                        data_d[idx_q] = v;
                        if (idx_q == IDX_LAST) begin
                            stop_d  = 1'b0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        perr_d  = ((^data_q) ^ v) != (PARITY == 2);
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!v) begin
                            frame_err = 1'b1;
                            state_d   = S_WAIT_HIGH;
                        end else if (stop_q == STOP_LAST) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    // A stuck-low line must go idle before a new start bit can be seen.
                    if (v) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (!en) begin
            state_d   = S_IDLE;
            push      = 1'b0;
            frame_err = 1'b0;
        end
    end

    always_comb begin
        pop      = (count_q != '0) && m.m_ready;
        full     = (count_q == FULL_CNT);
        wr_en    = push && (!full || pop);
        ovf_d    = push && full && !pop;
        ferr_d   = frame_err;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        // Once empty, the last popped word stays on the output.
        head = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sync_q   <= 2'b11;
            vote_q   <= 3'b111;
            cnt_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            vote_q   <= vote_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[wr_ptr_q] <= {perr_q, data_q};
    end

    assign m.m_data   = head[DATA_BITS-1:0];
    assign m.m_perr   = head[DATA_BITS];
    assign m.m_valid  = (count_q != '0);
    assign busy       = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign ferr       = ferr_q;
    assign ovf        = ovf_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: instance A is 8N1 with a 4-deep FIFO, instance B is 8O1.
module tb_uart_rx_fifo;
    localparam int BIT = 32;  // 16 ticks per bit, one tick every 2 clocks

    logic clk = 1'b0;
    logic tick = 1'b0;
    logic rst_n, en, rx_a, rx_b;
    logic busy_a, ferr_a, ovf_a, busy_b, ferr_b, ovf_b;
    logic [2:0] cnt_a, cnt_b;
    int checks = 0;
    int errors = 0;
    int ferr_cnt_a = 0, ovf_cnt_a = 0, busy_cyc_a = 0;
    logic [8:0] cap_a[$];
    logic [8:0] cap_b[$];
    int n0, f0, o0, b0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= ~tick;

    uart_rx_fifo_if #(.DATA_BITS(8)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(8)) ifb ();

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_tick(tick), .rx(rx_a), .m(ifa.master),
        .busy(busy_a), .ferr(ferr_a), .ovf(ovf_a), .fifo_count(cnt_a));

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_tick(tick), .rx(rx_b), .m(ifb.master),
        .busy(busy_b), .ferr(ferr_b), .ovf(ovf_b), .fifo_count(cnt_b));

    always @(posedge clk) begin
        if (rst_n && ifa.m_valid && ifa.m_ready) cap_a.push_back({ifa.m_perr, ifa.m_data});
        if (rst_n && ifb.m_valid && ifb.m_ready) cap_b.push_back({ifb.m_perr, ifb.m_data});
        ferr_cnt_a <= ferr_cnt_a + (ferr_a ? 1 : 0);
        ovf_cnt_a  <= ovf_cnt_a + (ovf_a ? 1 : 0);
        busy_cyc_a <= busy_cyc_a + (busy_a ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input bit which, input logic b);
        if (which) rx_b = b; else rx_a = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stopv);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
        drive_bit(0, stopv);
        drive_bit(0, 1'b1);
    endtask

    task automatic send_b(input logic [7:0] d, input logic parbit);
        drive_bit(1, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1, d[i]);
        drive_bit(1, parbit);
        drive_bit(1, 1'b1);
        drive_bit(1, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        ifa.m_ready = 1'b1; ifb.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", ifa.m_valid, 0);
        chk("rst_data", ifa.m_data, 0);
        chk("rst_perr", ifa.m_perr, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_count", cnt_a, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        n0 = cap_a.size();
        send_a(8'hA5, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("a5_beats", cap_a.size() - n0, 1);
        chk("a5_word", cap_a[n0], 9'h0A5);
        chk("a5_ferr", ferr_cnt_a, 0);
        chk("a5_ovf", ovf_cnt_a, 0);

        // 0x3C has four ones: parity bit 0 is wrong for odd parity, 1 is right
        send_b(8'h3C, 1'b0);
        send_b(8'h3C, 1'b1);
        chk("par_beats", cap_b.size(), 2);
        chk("par_bad_word", cap_b[0], 9'h13C);
        chk("par_good_word", cap_b[1], 9'h03C);

        b0 = busy_cyc_a; f0 = ferr_cnt_a; n0 = cap_a.size();
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_busy_seen", (busy_cyc_a - b0) > 0, 1);
        chk("glitch_busy_short", (busy_cyc_a - b0) <= BIT, 1);
        chk("glitch_busy_end", busy_a, 0);
        chk("glitch_ferr", ferr_cnt_a - f0, 0);
        chk("glitch_push", cap_a.size() - n0, 0);
        chk("glitch_count", cnt_a, 0);

        f0 = ferr_cnt_a; n0 = cap_a.size();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, 1'b1);
        rx_a = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("brk_ferr_once", ferr_cnt_a - f0, 1);
        chk("brk_no_push", cap_a.size() - n0, 0);
        send_a(8'h55, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("brk_next_beats", cap_a.size() - n0, 1);
        chk("brk_next_word", cap_a[n0], 9'h055);

        ifa.m_ready = 1'b0;
        o0 = ovf_cnt_a;
        for (int i = 1; i <= 4; i++) send_a(8'(i), 1'b1);
        chk("fill_count", cnt_a, 4);
        chk("fill_no_ovf", ovf_cnt_a - o0, 0);
        send_a(8'h05, 1'b1);
        chk("ovf_pulse", ovf_cnt_a - o0, 1);
        chk("ovf_count", cnt_a, 4);
        chk("ovf_head", ifa.m_data, 8'h01);
        n0 = cap_a.size();
        ifa.m_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("drain_beats", cap_a.size() - n0, 4);
        for (int i = 0; i < 4; i++) chk("drain_order", cap_a[n0 + i], 9'(i + 1));
        chk("drain_valid", ifa.m_valid, 0);
        chk("drain_hold", ifa.m_data, 8'h04);
        chk("drain_count", cnt_a, 0);

        n0 = cap_a.size();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
        rx_a = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        chk("rst_mid_busy_before", busy_a, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy_after", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5 * BIT) @(negedge clk);
        send_a(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("rst_mid_beats", cap_a.size() - n0, 1);
        chk("rst_mid_word", cap_a[n0], 9'h081);

        n0 = cap_a.size();
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
        rx_a = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        chk("en_mid_busy_before", busy_a, 1);
        en = 1'b0;
        @(posedge clk); #1;
        chk("en_mid_busy_after", busy_a, 0);
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (5 * BIT) @(negedge clk);
        send_a(8'h81, 1'b1);
        repeat (BIT) @(negedge clk);
        chk("en_mid_beats", cap_a.size() - n0, 1);
        chk("en_mid_word", cap_a[n0], 9'h081);
        chk("total_ferr", ferr_cnt_a, 1);
        chk("total_ovf", ovf_cnt_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
